// File: rtl/cmp_sched_pkg.sv
// Shared types and helpers for the round-robin comparator scheduler.
// Holds the result struct, the FSM state enum and the compare function.
package cmp_sched_pkg;

    localparam int STALL_W   = 16;
    localparam int CMP_MAX_W = 32;

    typedef struct packed {
        logic greater;
        logic equal;
        logic lesser;
    } cmp_res_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sched_state_t;

    // Callers zero-extend narrower operands, so the comparison stays unsigned.
    function automatic cmp_res_t cmp3(input logic [CMP_MAX_W-1:0] a,
                                      input logic [CMP_MAX_W-1:0] b);
        cmp_res_t r;
        r.greater = (a > b);
        r.equal   = (a == b);
        r.lesser  = (a < b);
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its binary index.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            idx = sum[IDW-1:0];
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_rr_scheduler.sv
// Round-robin scheduler sharing one registered unsigned comparator among NREQ requesters.
// Optional macro CMP_STALL_CNT_EN adds a saturating stall_cnt output.
module cmp_rr_scheduler
    import cmp_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 3,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              greater,
    output logic              equal,
    output logic              lesser
`ifdef CMP_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    sched_state_t   state, state_nxt;
    logic           accept;
    logic           grant;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] ptr;
    logic [W-1:0]   a_sel, b_sel;
    cmp_res_t       res_q;

    // A held result blocks new grants until the consumer takes it.
    assign accept = (state == EMPTY) || rsp_ready;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .en     (accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign grant = |gnt;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (grant)
            state_nxt = FULL;
        else if (state == FULL && rsp_ready)
            state_nxt = EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            ptr    <= '0;
            rsp_id <= '0;
            res_q  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                res_q  <= cmp3(CMP_MAX_W'(a_sel), CMP_MAX_W'(b_sel));
                rsp_id <= gnt_id;
                ptr    <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    assign rsp_valid = (state == FULL);
    assign greater   = res_q.greater;
    assign equal     = res_q.equal;
    assign lesser    = res_q.lesser;

`ifdef CMP_STALL_CNT_EN
    logic stall;
    assign stall = (|req) && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_cmp_rr_scheduler.sv
// Self-checking bench for cmp_rr_scheduler (NREQ=4, W=3) using a result scoreboard.
// Define CMP_STALL_CNT_EN to also exercise the stall counter.
module tb_cmp_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 3;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              greater, equal, lesser;
`ifdef CMP_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    cmp_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .greater   (greater),
        .equal     (equal),
        .lesser    (lesser)
`ifdef CMP_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [2:0]     res;
    } exp_t;

    exp_t exp_q[$];

    // {greater, equal, lesser}
    function automatic logic [2:0] ref_cmp(input int a, input int b);
        if (a > b)  return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, greater, equal, lesser} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b",
                     {rsp_valid, rsp_id, greater, equal, lesser}, 6'b0);
        end
        rst = 1'b0;
        set_ops(1, 4, 1);
        req = 4'b0010;
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_pre_gnt: got %b expected %b", gnt, 4'b0010);
        end
        exp_q.push_back('{id: 2'd1, res: ref_cmp(4, 1)});
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({rsp_valid, rsp_id, greater, equal, lesser} !== {1'b1, e.id, e.res}) begin
            n_fail++;
            $display("FAIL reset_pre_result: got %b expected %b",
                     {rsp_valid, rsp_id, greater, equal, lesser}, {1'b1, e.id, e.res});
        end
        req = '0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, greater, equal, lesser} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_midstream: got %b expected %b",
                     {rsp_valid, rsp_id, greater, equal, lesser}, 6'b0);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, i, 7 - i);
        req = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_ptr: got gnt %b expected %b", gnt, 4'b0001);
        end
        req = '0;
        tick();
    endtask

    task automatic test_single();
        int va[3] = '{5, 6, 2};
        int vb[3] = '{3, 6, 7};
        exp_t e;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_ops(0, va[k], vb[k]);
            req = 4'b0001;
            #1;
            n_checks++;
            if (gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL single_gnt[%0d]: got %b expected %b", k, gnt, 4'b0001);
            end
            exp_q.push_back('{id: 2'd0, res: ref_cmp(va[k], vb[k])});
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_id, greater, equal, lesser} !== {1'b1, e.id, e.res}) begin
                n_fail++;
                $display("FAIL single_result[%0d]: got %b expected %b", k,
                         {rsp_valid, rsp_id, greater, equal, lesser}, {1'b1, e.id, e.res});
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_fairness();
        int va[4] = '{1, 5, 3, 7};
        int vb[4] = '{4, 5, 0, 2};
        exp_t e;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_ops(i, va[i], vb[i]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (gnt !== (4'b0001 << (k % 4))) begin
                n_fail++;
                $display("FAIL fair_gnt[%0d]: got %b expected %b", k, gnt, 4'b0001 << (k % 4));
            end
            exp_q.push_back('{id: IDW'(k % 4), res: ref_cmp(va[k % 4], vb[k % 4])});
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_id, greater, equal, lesser} !== {1'b1, e.id, e.res}) begin
                n_fail++;
                $display("FAIL fair_result[%0d]: got %b expected %b", k,
                         {rsp_valid, rsp_id, greater, equal, lesser}, {1'b1, e.id, e.res});
            end
        end
        req = '0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_gnt: got %b expected %b", gnt, 4'b0000);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, greater, equal, lesser} !== {1'b0, 2'd0, ref_cmp(1, 4)}) begin
            n_fail++;
            $display("FAIL drain_hold: got %b expected %b",
                     {rsp_valid, rsp_id, greater, equal, lesser}, {1'b0, 2'd0, ref_cmp(1, 4)});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t held;
        set_ops(1, 3, 6);
        set_ops(2, 6, 2);
        rsp_ready = 1'b0;
        req = 4'b0110;
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_first_gnt: got %b expected %b", gnt, 4'b0010);
        end
        exp_q.push_back('{id: 2'd1, res: ref_cmp(3, 6)});
        tick();
        held = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (gnt !== 4'b0000 ||
                {rsp_valid, rsp_id, greater, equal, lesser} !== {1'b1, held.id, held.res}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got gnt %b out %b expected gnt %b out %b", k, gnt,
                         {rsp_valid, rsp_id, greater, equal, lesser}, 4'b0000,
                         {1'b1, held.id, held.res});
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_release_gnt: got %b expected %b", gnt, 4'b0100);
        end
        exp_q.push_back('{id: 2'd2, res: ref_cmp(6, 2)});
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({rsp_valid, rsp_id, greater, equal, lesser} !== {1'b1, e.id, e.res}) begin
            n_fail++;
            $display("FAIL bp_release_result: got %b expected %b",
                     {rsp_valid, rsp_id, greater, equal, lesser}, {1'b1, e.id, e.res});
        end
        #1;
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_wrap_gnt: got %b expected %b", gnt, 4'b0010);
        end
        exp_q.push_back('{id: 2'd1, res: ref_cmp(3, 6)});
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({rsp_valid, rsp_id, greater, equal, lesser} !== {1'b1, e.id, e.res}) begin
            n_fail++;
            $display("FAIL bp_wrap_result: got %b expected %b",
                     {rsp_valid, rsp_id, greater, equal, lesser}, {1'b1, e.id, e.res});
        end
        req = '0;
        tick();
    endtask

    task automatic test_boundary();
        int va[3] = '{7, 0, 0};
        int vb[3] = '{0, 7, 0};
        exp_t e;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_ops(3, va[k], vb[k]);
            req = 4'b1000;
            #1;
            n_checks++;
            if (gnt !== 4'b1000) begin
                n_fail++;
                $display("FAIL bound_gnt[%0d]: got %b expected %b", k, gnt, 4'b1000);
            end
            exp_q.push_back('{id: 2'd3, res: ref_cmp(va[k], vb[k])});
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if ({rsp_valid, rsp_id, greater, equal, lesser} !== {1'b1, e.id, e.res} ||
                !$onehot({greater, equal, lesser})) begin
                n_fail++;
                $display("FAIL bound_result[%0d]: got %b expected %b", k,
                         {rsp_valid, rsp_id, greater, equal, lesser}, {1'b1, e.id, e.res});
            end
        end
        req = '0;
        tick();
    endtask

`ifdef CMP_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        set_ops(0, 1, 1);
        rsp_ready = 1'b0;
        req = 4'b0001;
        tick();
        repeat (10) tick();
        n_checks++;
        if (stall_cnt !== 16'd10) begin
            n_fail++;
            $display("FAIL stall_cnt_10: got %0d expected %0d", stall_cnt, 10);
        end
        repeat (70000) tick();
        n_checks++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stall_cnt_sat: got %h expected %h", stall_cnt, 16'hFFFF);
        end
        req = '0;
        rsp_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_boundary();
`ifdef CMP_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
